// File: rtl/ram_clr_pkg.sv
// Shared types and defaults for the clearing RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_clr_pkg;

  // Sequencer state: CLEAR while the sweep runs, READY once every word is cleared.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_clr_state_t;

  localparam int RAM_CLR_WIDTH_DEF = 16;
  localparam int RAM_CLR_DEPTH_DEF = 512;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks cnt from 0 to DEPTH-1 after reset, one word per edge.
// Latency: busy is registered; it rises at the first edge sampling reset=1 and falls after word DEPTH-1 is written.
// Backpressure: none; user writes are blocked by the parent while busy=1.
// Ports:
//   clk         system clock
//   reset       synchronous active-high; starts or restarts the sweep
//   busy        high while the sweep runs (state == CLEAR)
//   sweep_addr  word being cleared this cycle
//   sweep_we    strobe: write CLEAR_VALUE to sweep_addr at this edge
module ram_clr_seq
  import ram_clr_pkg::*;
#(
  parameter int DEPTH = RAM_CLR_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic [AW-1:0] sweep_addr,
  output logic          sweep_we
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_clr_state_t state, state_nxt;
  logic [AW-1:0]  cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // On the last word, cnt holds at DEPTH-1 instead of wrapping; READY takes over.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = READY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign busy       = (state == CLEAR);
  assign sweep_addr = cnt;
  // A reset edge must leave the array untouched, so the strobe is gated by reset.
  assign sweep_we   = (state == CLEAR) && !reset;

endmodule

// File: rtl/ram_clr.sv
// Single-port synchronous RAM with a hardware clear sweep after every reset.
// Latency: write at edge N; read combinational (default) or one edge later with RAM_CLR_READ_REG_EN (read-first).
// Backpressure: user writes dropped while busy=1; out forced to 0 while busy=1.
// Ports:
//   clk      system clock
//   reset    synchronous active-high; restarts the clear sweep
//   in       write data
//   address  read/write address; addresses >= DEPTH ignore writes and read 0
//   load     write enable (ignored while busy)
//   out      read data
//   busy     high while the clear sweep runs
// Build option: define RAM_CLR_READ_REG_EN for a registered read port.
module ram_clr
  import ram_clr_pkg::*;
#(
  parameter int               WIDTH       = RAM_CLR_WIDTH_DEF,
  parameter int               DEPTH       = RAM_CLR_DEPTH_DEF,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int              AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    address,
  input  logic             load,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             in_range;
  logic             user_we;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_dat;
  logic [WIDTH-1:0] rd_dat;

  ram_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  // Only matters when DEPTH is not a power of two.
  assign in_range = ({1'b0, address} < (AW + 1)'(DEPTH));

  assign user_we = load && !busy && !reset && in_range;

  // One shared write port keeps the array a plain block-RAM template.
  assign wr_en   = sweep_we || user_we;
  assign wr_addr = busy ? sweep_addr : address;
  assign wr_dat  = busy ? CLEAR_VALUE : in;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = in_range ? mem[address] : '0;

`ifdef RAM_CLR_READ_REG_EN
  // Read-first: the array update is non-blocking, so a same-edge write shows next edge.
  // Cleared on reset and throughout CLEAR, including the edge where busy falls.
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (reset || busy) begin
      out_q <= '0;
    end else begin
      out_q <= rd_dat;
    end
  end

  assign out = out_q;
`else
  assign out = busy ? '0 : rd_dat;
`endif

endmodule
